// File: rtl/rom_frame_reader.sv
// Fetches a run of consecutive constant-ROM words and serializes each one
// MSB-first onto a valid/ready bit stream for the CAN transmit path.
module rom_frame_reader #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read,
  input  logic [DATA_W-1:0] rom_data,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] words_q;
  logic [DATA_W-1:0] shift_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [LAT_W-1:0]  lat_q;
  logic              rom_read_q;
  logic              bit_out_q;
  logic              bit_valid_q;
  logic              busy_q;
  logic              done_q;

  assign rom_addr  = addr_q;
  assign rom_read  = rom_read_q;
  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Whole controller; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      words_q     <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      lat_q       <= '0;
      rom_read_q  <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            words_q <= word_count;
            busy_q  <= 1'b1;
            if (word_count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= FETCH;
              addr_q     <= base_addr;
              rom_read_q <= 1'b1;
              lat_q      <= '0;
            end
          end
        end

        FETCH: begin
          // Address and strobe stay put until the ROM latency has elapsed.
          if (lat_q == LAT_W'(ROM_LAT - 1)) begin
            shift_q     <= rom_data;
            bit_out_q   <= rom_data[DATA_W-1];
            bit_valid_q <= 1'b1;
            rom_read_q  <= 1'b0;
            bit_cnt_q   <= '0;
            lat_q       <= '0;
            state_q     <= SHIFT;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end

        SHIFT: begin
          if (bit_ready) begin
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              bit_valid_q <= 1'b0;
              bit_out_q   <= 1'b0;
              bit_cnt_q   <= '0;
              shift_q     <= '0;
              words_q     <= words_q - ADDR_W'(1);
              if (words_q == ADDR_W'(1)) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                addr_q     <= addr_q + ADDR_W'(1);
                rom_read_q <= 1'b1;
                state_q    <= FETCH;
              end
            end else begin
              shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
              bit_out_q <= shift_q[DATA_W-2];
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_frame_reader.sv
// Scoreboard bench for rom_frame_reader: expected ROM addresses and words are
// queued at start time and matched against what the serial stream delivers.
module tb_rom_frame_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  base_addr;
  logic [5:0]  word_count;
  logic [5:0]  rom_addr;
  logic        rom_read;
  logic [31:0] rom_data;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        busy;
  logic        done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [5:0]  addr_q[$];
  logic [31:0] word_q[$];

  int unsigned mon_bits = 0;
  logic [31:0] mon_word = '0;
  int unsigned done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic        prev_bit   = 1'b0;
  logic        prev_read  = 1'b0;
  logic        bp_en      = 1'b0;

  rom_frame_reader #(.ADDR_W(6), .DATA_W(32), .ROM_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .rom_addr   (rom_addr),
    .rom_read   (rom_read),
    .rom_data   (rom_data),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Constant ROM: data is a pure function of the stable address.
  assign rom_data = 32'hA500_0000 | {26'd0, rom_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Ready toggles every cycle while backpressure is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) bit_ready = ~bit_ready;
    end
  end

  // Stream monitor: protocol checks and word assembly against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_bits   = 0;
      mon_word   = '0;
      prev_stall = 1'b0;
      prev_bit   = 1'b0;
      prev_read  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, bit_valid}, 32'd1);
        chk("hold_bit", {31'd0, bit_out}, {31'd0, prev_bit});
      end
      if (mon_bits != 0) chk("valid_midword", {31'd0, bit_valid}, 32'd1);
      if (rom_read && !prev_read) begin
        if (addr_q.size() == 0) chk("rom_read_unexpected", 32'd1, 32'd0);
        else chk("rom_addr", {26'd0, rom_addr}, {26'd0, addr_q.pop_front()});
      end
      if (bit_valid && bit_ready) begin
        mon_word = {mon_word[30:0], bit_out};
        mon_bits++;
        if (mon_bits == 32) begin
          if (word_q.size() == 0) chk("word_unexpected", mon_word, 32'hFFFF_FFFF);
          else chk("word", mon_word, word_q.pop_front());
          mon_bits = 0;
        end
      end
      if (done) done_cnt++;
      prev_stall = bit_valid && !bit_ready;
      prev_bit   = bit_out;
      prev_read  = rom_read;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rom_addr"}, {26'd0, rom_addr}, 32'd0);
    chk({tag, "_rom_read"}, {31'd0, rom_read}, 32'd0);
    chk({tag, "_bit_out"}, {31'd0, bit_out}, 32'd0);
    chk({tag, "_bit_valid"}, {31'd0, bit_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  // Pulses start for one cycle; returns #1 into cycle 1.
  task automatic do_start(input logic [5:0] base, input logic [5:0] cnt);
    logic [5:0] a;
    @(posedge clk);
    #1;
    a = base;
    for (int i = 0; i < int'(cnt); i++) begin
      addr_q.push_back(a);
      word_q.push_back(32'hA500_0000 | {26'd0, a});
      a = a + 6'd1;
    end
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    bit seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  int unsigned d0;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    bit_ready  = 1'b1;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("idle_no_read", {31'd0, rom_read}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Single word with exact latency
    d0 = done_cnt;
    do_start(6'd5, 6'd1);
    chk("c1_rom_read", {31'd0, rom_read}, 32'd1);
    chk("c1_rom_addr", {26'd0, rom_addr}, 32'd5);
    chk("c1_valid", {31'd0, bit_valid}, 32'd0);
    chk("c1_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("c2_valid", {31'd0, bit_valid}, 32'd1);
    chk("c2_bit", {31'd0, bit_out}, 32'd1);
    chk("c2_rom_read", {31'd0, rom_read}, 32'd0);
    repeat (31) @(posedge clk);
    #1;
    chk("c33_valid", {31'd0, bit_valid}, 32'd1);
    chk("c33_bit", {31'd0, bit_out}, 32'd1);
    @(posedge clk);
    #1;
    chk("c34_done", {31'd0, done}, 32'd1);
    chk("c34_busy", {31'd0, busy}, 32'd1);
    chk("c34_valid", {31'd0, bit_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("c35_done", {31'd0, done}, 32'd0);
    chk("c35_busy", {31'd0, busy}, 32'd0);
    chk("single_done_cnt", done_cnt - d0, 32'd1);

    // Backpressure
    d0 = done_cnt;
    bp_en = 1'b1;
    do_start(6'd0, 6'd1);
    wait_done(200);
    bp_en = 1'b0;
    bit_ready = 1'b1;
    chk("bp_done_cnt", done_cnt - d0, 32'd1);

    // Multi-word address wrap
    d0 = done_cnt;
    do_start(6'd62, 6'd3);
    wait_done(300);
    chk("wrap_done_cnt", done_cnt - d0, 32'd1);

    // Zero count
    d0 = done_cnt;
    do_start(6'd9, 6'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd1);
    chk("zero_read", {31'd0, rom_read}, 32'd0);
    @(posedge clk);
    #1;
    chk("zero_done_end", {31'd0, done}, 32'd0);
    chk("zero_busy_end", {31'd0, busy}, 32'd0);
    chk("zero_done_cnt", done_cnt - d0, 32'd1);

    // Start while busy is ignored
    d0 = done_cnt;
    do_start(6'd30, 6'd2);
    repeat (10) @(posedge clk);
    #1;
    start      = 1'b1;
    base_addr  = 6'd10;
    word_count = 6'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_start_busy", {31'd0, busy}, 32'd1);
    wait_done(300);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_start_done_cnt", done_cnt - d0, 32'd1);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    // Reset mid-run, then a clean run
    d0 = done_cnt;
    do_start(6'd20, 6'd2);
    for (int i = 0; i < 200; i++) begin
      if (mon_bits == 15) break;
      @(posedge clk);
      #1;
    end
    chk("midrun_reached_bit15", mon_bits, 32'd15);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrun_reset");
    addr_q.delete();
    word_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun_no_done", done_cnt - d0, 32'd0);
    chk("midrun_idle_busy", {31'd0, busy}, 32'd0);
    do_start(6'd7, 6'd1);
    wait_done(200);
    chk("post_reset_done_cnt", done_cnt - d0, 32'd1);

    chk("addr_q_empty", addr_q.size(), 32'd0);
    chk("word_q_empty", word_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_frame_reader.md
Name: rom_frame_reader

Overview:
Master-side reader for the constant ROM interface (6-bit address, read strobe, 32-bit data). On a start pulse it fetches a run of consecutive ROM words and serializes each word MSB-first onto a valid/ready bit stream. The bit stream feeds the CAN transmit path with preloaded frame fields such as identifiers, control bits and fixed payloads.

Parameters:
ADDR_W, 6, ROM address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 32, ROM word width; bits shifted per word.
ROM_LAT, 1, cycles from rom_addr/rom_read valid to rom_data valid; legal range 1..4.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request; sampled only in IDLE.
base_addr  input  ADDR_W  first ROM address; latched on accepted start.
word_count  input  ADDR_W  number of words to stream; latched on accepted start; 0 means no fetch.
rom_addr  output  ADDR_W  address to ROM.
rom_read  output  1  ROM read enable.
rom_data  input  DATA_W  ROM read data.
bit_out  output  1  current serial bit.
bit_valid  output  1  bit_out is valid.
bit_ready  input  1  downstream accepts bit_out when bit_valid is also high.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse when the run completes.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n. Asserting rst_n=0 forces:
  - state to IDLE;
  - rom_addr=0, rom_read=0;
  - bit_out=0, bit_valid=0;
  - busy=0, done=0;
  - shift register, word counter, bit counter and latency counter all to 0.
- Reset mid-run: the run is abandoned immediately. No done pulse is issued. After release, the block idles until a new start.
- All outputs are registered.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - start=1 latches base_addr and word_count.
  - If word_count=0, go to DONE. Otherwise go to FETCH with rom_addr=base_addr.
  - start in any other state is ignored (not queued).
- FETCH:
  - rom_read=1 and rom_addr held stable for ROM_LAT cycles.
  - On the clock edge ending the ROM_LAT-th cycle, capture rom_data into the shift register and go to SHIFT.
  - rom_read deasserts in SHIFT.
- SHIFT:
  - bit_valid=1 and bit_out=shift register MSB.
  - On bit_valid and bit_ready: shift left by one and increment the bit counter.
  - If bit_ready=0, bit_out is held with no change.
  - After the DATA_W-th accepted bit, decrement the remaining word count and drop bit_valid for that next cycle.
  - If words remain: rom_addr increments by 1 modulo 2^ADDR_W (63 wraps to 0), then go to FETCH.
  - If no words remain: go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Latency, ROM_LAT=1, start sampled at edge E0:
  - rom_read=1 during cycle 1.
  - bit_valid=1 from cycle 2.
  - First bit is accepted at the earliest in cycle 2.
  - Word N+1 first bit is presented 2 cycles after the last bit of word N is accepted (ROM_LAT+1).
- Total stream length is word_count*DATA_W bits. bit_valid never drops mid-word.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release. All outputs 0, busy=0. No rom_read for 10 cycles without start.
- Single word: bench ROM returns 32'hA5000000|addr. Start with base=5, count=1, bit_ready=1 constantly.
  - rom_read=1 only in cycle 1 with rom_addr=5.
  - 32 bits stream 1010_0101_..._0000_0101 in cycles 2..33.
  - done pulses in cycle 34, busy=0 in cycle 35.
- Backpressure: same ROM, base=0, count=1. Toggle bit_ready 1/0 every cycle.
  - bit_out is stable while bit_ready=0.
  - Exactly 32 accepted bits equal to 32'hA5000000.
  - bit_valid is never low mid-word.
- Multi-word wrap: base=62, count=3. rom_addr sequence is 62, 63, 0. Received words are A500003E, A500003F, A5000000. One done pulse.
- Zero count and start-while-busy:
  - count=0: done in cycle 1, never any rom_read.
  - During a 2-word run, pulse start with base=10. The pulse is ignored: rom_addr is never 10.
- Reset mid-run: assert rst_n=0 during bit 15 of word 1. All outputs return to 0 at once, with no done pulse. A new start with base=7, count=1 streams A5000007 correctly.
